// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the controller (drives stage enables/flushes); slave: the pipeline datapath.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_isValid;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_isValid;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        dmem_ready;

  logic        dmem_req;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        pc_redirect;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic        mem_timeout_err;
  logic [31:0] perf_cycles;
  logic [31:0] perf_mem_stall;
  logic [31:0] perf_lu_stall;
  logic [31:0] perf_flush;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_isValid, ex_rd, ex_mem_read, ex_branch_taken,
    input  mem_isValid, mem_mem_read, mem_mem_write, dmem_ready,
    output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output pc_redirect, ifid_flush, idex_flush, memwb_bubble,
    output mem_timeout_err,
    output perf_cycles, perf_mem_stall, perf_lu_stall, perf_flush
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_isValid, ex_rd, ex_mem_read, ex_branch_taken,
    output mem_isValid, mem_mem_read, mem_mem_write, dmem_ready,
    input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  pc_redirect, ifid_flush, idex_flush, memwb_bubble,
    input  mem_timeout_err,
    input  perf_cycles, perf_mem_stall, perf_lu_stall, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch redirect, data-memory wait + watchdog.
// Optional performance counters are compiled in with PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.master bus,
  output logic               o_dbg_state
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  logic w_mem_access;
  logic w_timeout_hit;
  logic w_mem_stall;
  logic w_branch;
  logic w_load_use;
  logic w_redirect;
  logic w_lu_stall;

  assign w_mem_access  = bus.mem_isValid & (bus.mem_mem_read | bus.mem_mem_write);
  // The watchdog cycle behaves as a completion so the pipeline moves on.
  assign w_timeout_hit = (r_state == MEM_WAIT) & w_mem_access & ~bus.dmem_ready &
                         (r_wait_cnt == TIMEOUT_CNT);
  assign w_mem_stall   = ~reset & w_mem_access & ~bus.dmem_ready & ~w_timeout_hit;

  assign w_branch   = bus.ex_isValid & bus.ex_branch_taken;
  assign w_load_use = bus.ex_isValid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                      ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
  // A redirect flushes the ID instruction, so it wins over load-use.
  assign w_redirect = ~reset & ~w_mem_stall & w_branch;
  assign w_lu_stall = ~reset & ~w_mem_stall & ~w_branch & w_load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (w_timeout_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= RUN;
          end else if (!w_mem_stall) begin
            r_state <= RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.dmem_req     = 1'b0;
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.idex_en      = 1'b1;
    bus.exmem_en     = 1'b1;
    bus.memwb_en     = 1'b1;
    bus.pc_redirect  = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.memwb_bubble = 1'b0;
    if (reset) begin
      bus.pc_en        = 1'b0;
      bus.ifid_en      = 1'b0;
      bus.idex_en      = 1'b0;
      bus.exmem_en     = 1'b0;
      bus.memwb_en     = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idex_flush   = 1'b1;
      bus.memwb_bubble = 1'b1;
    end else begin
      bus.dmem_req = w_mem_access;
      if (w_mem_stall) begin
        // Freeze PC..EX/MEM; MEM/WB keeps loading bubbles behind the stalled access.
        bus.pc_en        = 1'b0;
        bus.ifid_en      = 1'b0;
        bus.idex_en      = 1'b0;
        bus.exmem_en     = 1'b0;
        bus.memwb_bubble = 1'b1;
      end else if (w_redirect) begin
        bus.pc_redirect = 1'b1;
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
      end else if (w_lu_stall) begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
    end
  end

  assign bus.mem_timeout_err = r_timeout_err;
  assign o_dbg_state         = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_mem_stall;
  logic [31:0] r_perf_lu_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles    <= 32'd0;
      r_perf_mem_stall <= 32'd0;
      r_perf_lu_stall  <= 32'd0;
      r_perf_flush     <= 32'd0;
    end else begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_mem_stall) r_perf_mem_stall <= r_perf_mem_stall + 32'd1;
      if (w_lu_stall)  r_perf_lu_stall  <= r_perf_lu_stall + 32'd1;
      if (w_redirect)  r_perf_flush     <= r_perf_flush + 32'd1;
    end
  end

  assign bus.perf_cycles    = r_perf_cycles;
  assign bus.perf_mem_stall = r_perf_mem_stall;
  assign bus.perf_lu_stall  = r_perf_lu_stall;
  assign bus.perf_flush     = r_perf_flush;
`else
  assign bus.perf_cycles    = 32'd0;
  assign bus.perf_mem_stall = 32'd0;
  assign bus.perf_lu_stall  = 32'd0;
  assign bus.perf_flush     = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect, memory wait, watchdog, reset abort.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_redirect, ifid_flush, idex_flush, memwb_bubble, dmem_req}
  localparam logic [9:0] C_RST  = 10'b00000_0111_0;
  localparam logic [9:0] C_DEF  = 10'b11111_0000_0;
  localparam logic [9:0] C_LU   = 10'b00111_0010_0;
  localparam logic [9:0] C_MS   = 10'b00001_0001_1;
  localparam logic [9:0] C_DONE = 10'b11111_0000_1;
  localparam logic [9:0] C_RDR  = 10'b11111_1110_0;
  localparam logic [9:0] C_RDRM = 10'b11111_1110_1;

  logic clk;
  logic reset;
  logic dbg_state;
  logic [9:0] ctl;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  assign ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.pc_redirect, bus.ifid_flush, bus.idex_flush, bus.memwb_bubble, bus.dmem_req};

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];
  int unsigned e_cyc = 0;
  int unsigned e_ms  = 0;
  int unsigned e_lu  = 0;
  int unsigned e_fl  = 0;
  logic e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_isValid = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_isValid = 1'b0; bus.mem_mem_read = 1'b0;
    bus.mem_mem_write = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Checks the combinational controls mid-cycle, then advances one clock.
  task automatic cycle(input string tag, input logic [9:0] exp_ctl);
    exp_q.push_back(exp_ctl);
    @(negedge clk);
    chk(tag, 32'(ctl), 32'(exp_q.pop_front()));
    if (reset) begin
      e_cyc = 0; e_ms = 0; e_lu = 0; e_fl = 0; e_err = 1'b0;
    end else begin
      e_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic exp_state);
    chk({tag, "_state"}, 32'(dbg_state), 32'(exp_state));
    chk({tag, "_err"}, 32'(bus.mem_timeout_err), 32'(e_err));
    chk({tag, "_pcyc"}, bus.perf_cycles, PERF ? e_cyc : 32'd0);
    chk({tag, "_pms"}, bus.perf_mem_stall, PERF ? e_ms : 32'd0);
    chk({tag, "_plu"}, bus.perf_lu_stall, PERF ? e_lu : 32'd0);
    chk({tag, "_pfl"}, bus.perf_flush, PERF ? e_fl : 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    // A pending access during reset must not raise dmem_req.
    bus.mem_isValid = 1'b1; bus.mem_mem_read = 1'b1;
    cycle("rst0", C_RST);
    cycle("rst1", C_RST);
    check_regs("rst", 1'b0);
    reset = 1'b0;
    idle_inputs();
    cycle("idle", C_DEF);
    check_regs("idle", 1'b0);

    // Load x5 in EX, ID reads rs2=x5: one bubble then normal.
    bus.ex_isValid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    bus.id_uses_rs1 = 1'b1; bus.id_rs1 = 5'd3;
    bus.id_uses_rs2 = 1'b1; bus.id_rs2 = 5'd5;
    cycle("lu_rs2", C_LU); e_lu++;
    bus.ex_isValid = 1'b0;
    cycle("lu_after", C_DEF);
    check_regs("lu", 1'b0);
    // Destination x0 is never a hazard.
    bus.ex_isValid = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
    cycle("lu_x0", C_DEF);
    // rs1 match, then the same match with rs1 unused.
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_rs2 = 5'd1;
    cycle("lu_rs1", C_LU); e_lu++;
    bus.id_uses_rs1 = 1'b0;
    cycle("lu_unused", C_DEF);
    idle_inputs();

    // Store waits 3 cycles for ready.
    bus.mem_isValid = 1'b1; bus.mem_mem_write = 1'b1;
    cycle("st_w0", C_MS); e_ms++;
    check_regs("st_w0", 1'b1);
    cycle("st_w1", C_MS); e_ms++;
    cycle("st_w2", C_MS); e_ms++;
    bus.dmem_ready = 1'b1;
    cycle("st_done", C_DONE);
    check_regs("st", 1'b0);
    // Ready in the request cycle: no stall.
    cycle("st_fast", C_DONE);
    check_regs("st_fast", 1'b0);
    idle_inputs();

    // Branch held behind a 2-cycle memory stall.
    bus.ex_isValid = 1'b1; bus.ex_branch_taken = 1'b1;
    bus.mem_isValid = 1'b1; bus.mem_mem_read = 1'b1;
    cycle("br_ms0", C_MS); e_ms++;
    cycle("br_ms1", C_MS); e_ms++;
    bus.dmem_ready = 1'b1;
    cycle("br_rdr", C_RDRM); e_fl++;
    check_regs("br", 1'b0);
    idle_inputs();

    // Redirect and load-use together: redirect only.
    bus.ex_isValid = 1'b1; bus.ex_branch_taken = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    bus.id_uses_rs2 = 1'b1; bus.id_rs2 = 5'd5;
    cycle("rdr_lu", C_RDR); e_fl++;
    check_regs("rdr_lu", 1'b0);
    idle_inputs();

    // Watchdog with MEM_TIMEOUT=4.
    bus.mem_isValid = 1'b1; bus.mem_mem_read = 1'b1;
    cycle("to_w0", C_MS); e_ms++;
    cycle("to_w1", C_MS); e_ms++;
    cycle("to_w2", C_MS); e_ms++;
    cycle("to_w3", C_MS); e_ms++;
    check_regs("to_pre", 1'b1);
    cycle("to_hit", C_DONE); e_err = 1'b1;
    check_regs("to_hit", 1'b0);
    idle_inputs();
    cycle("to_sticky", C_DEF);
    check_regs("to_sticky", 1'b0);

    // Reset during MEM_WAIT aborts the access.
    bus.mem_isValid = 1'b1; bus.mem_mem_read = 1'b1;
    cycle("ra_w0", C_MS); e_ms++;
    check_regs("ra_w0", 1'b1);
    reset = 1'b1;
    cycle("ra_rst", C_RST);
    check_regs("ra_rst", 1'b0);
    reset = 1'b0;
    idle_inputs();
    cycle("ra_idle", C_DEF);
    check_regs("ra_idle", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
